// File: rtl/encode_pkg.sv
// Shared constants and FSM state encoding for the coefficient byte encoder.
package encode_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/encode_coef_reduce.sv
// Maps a signed input coefficient to the D-bit unsigned value that gets packed.
// At 12 bits, negative coefficients are lifted into 0..q-1 by adding q;
// narrower widths just truncate to the low D bits.
module encode_coef_reduce
    import encode_pkg::*;
#(
    parameter int D = 12
) (
    input  logic [15:0]  coef,
    output logic [D-1:0] val
);

    generate
        if (D == 12) begin : g_mod_q
            // Only the low 12 bits matter: (coef + q) mod 4096 depends on coef[11:0] alone.
            logic [11:0] lifted;
            always_comb lifted = coef[11:0] + 12'(KYBER_Q);
            assign val = coef[15] ? lifted : coef[11:0];
        end else begin : g_trunc
            assign val = coef[D-1:0];
        end
    endgenerate

endmodule

// File: rtl/encode_seq.sv
// Streams N signed coefficients in, packs them LSB-first at D bits each, and
// emits 32*D bytes, byte 0 first, through a 20-bit bit buffer.
module encode_seq
    import encode_pkg::*;
#(
    parameter int D = 12,
    parameter int N = KYBER_N
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        coef_valid,
    input  logic [15:0] coef_data,
    output logic        coef_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_last,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    localparam int NBYTES = 32 * D;

    state_e      state_q, state_d;
    logic [19:0] bits_q, bits_d;
    logic [4:0]  fill_q, fill_d;
    logic [8:0]  ccnt_q, ccnt_d;
    logic [8:0]  bcnt_q, bcnt_d;
    logic        done_q;

    logic [D-1:0] coef_val;
    logic         coef_acc;
    logic         byte_acc;
    logic [19:0]  shifted;
    logic [4:0]   fill_s;

    encode_coef_reduce #(
        .D (D)
    ) u_reduce (
        .coef (coef_data),
        .val  (coef_val)
    );

    // Handshake flags and outputs, all from registered state.
    assign coef_ready = (state_q == ST_LOAD) && (fill_q < 5'd8);
    assign byte_valid = (fill_q >= 5'd8);
    assign byte_data  = bits_q[7:0];
    assign byte_last  = byte_valid && (bcnt_q == 9'(NBYTES - 1));
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign coef_acc   = coef_valid && coef_ready;
    assign byte_acc   = byte_valid && byte_ready;

    // Bit buffer: drop the consumed byte first, then append the new coefficient at fill.
    always_comb begin
        shifted = bits_q;
        fill_s  = fill_q;
        if (byte_acc) begin
            shifted = bits_q >> 8;
            fill_s  = fill_q - 5'd8;
        end
        bits_d = shifted;
        fill_d = fill_s;
        if (coef_acc) begin
            bits_d = shifted | (20'(coef_val) << fill_s);
            fill_d = fill_s + 5'(D);
        end
    end

    // Sequencing FSM and the coefficient/byte counters.
    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        bcnt_d  = bcnt_q;
        if (coef_acc) begin
            ccnt_d = (ccnt_q == 9'(N - 1)) ? 9'd0 : ccnt_q + 9'd1;
        end
        if (byte_acc) begin
            bcnt_d = byte_last ? 9'd0 : bcnt_q + 9'd1;
        end
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (coef_acc && (ccnt_q == 9'(N - 1))) state_d = ST_DRAIN;
            ST_DRAIN: if (byte_acc && byte_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any polynomial in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bits_q  <= '0;
            fill_q  <= '0;
            ccnt_q  <= '0;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            fill_q  <= fill_d;
            ccnt_q  <= ccnt_d;
            bcnt_q  <= bcnt_d;
            done_q  <= byte_acc && byte_last;
        end
    end

endmodule

// File: tb/tb_encode_seq.sv
// Directed bench for encode_seq at D=12 and D=1.
module tb_encode_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic        coef_valid = 1'b0;
    logic [15:0] coef_data = 16'd0;
    logic        byte_ready = 1'b1;

    logic        cr12, bv12, bl12, busy12, done12;
    logic [7:0]  bd12;
    logic        cr1, bv1, bl1, busy1, done1;
    logic [7:0]  bd1;
    logic        start12, start1;
    logic        m_cready, m_bvalid, m_last, m_busy, m_done;
    logic [7:0]  m_data;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cv [256];
    logic [7:0]  expb [384];
    logic [7:0]  got [$];
    bit          lastf [$];

    always #5 clk = ~clk;

    assign start12 = start & ~sel;
    assign start1  = start & sel;

    encode_seq #(.D(12), .N(256)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_ready(cr12), .byte_valid(bv12), .byte_data(bd12),
        .byte_last(bl12), .byte_ready(byte_ready), .busy(busy12), .done(done12)
    );

    encode_seq #(.D(1), .N(256)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .coef_valid(coef_valid),
        .coef_data(coef_data), .coef_ready(cr1), .byte_valid(bv1), .byte_data(bd1),
        .byte_last(bl1), .byte_ready(byte_ready), .busy(busy1), .done(done1)
    );

    assign m_cready = sel ? cr1 : cr12;
    assign m_bvalid = sel ? bv1 : bv12;
    assign m_data   = sel ? bd1 : bd12;
    assign m_last   = sel ? bl1 : bl12;
    assign m_busy   = sel ? busy1 : busy12;
    assign m_done   = sel ? done1 : done12;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_d12"}, {24'd0, cr12, bv12, bl12, busy12, done12, 3'd0} | {24'd0, bd12}, 32'd0);
        check({tag, "_d1"}, {24'd0, cr1, bv1, bl1, busy1, done1, 3'd0} | {24'd0, bd1}, 32'd0);
    endtask

    task automatic fill_rand(input int c0, input int c1);
        int r;
        cv[0] = c0[15:0];
        cv[1] = c1[15:0];
        for (int i = 2; i < 256; i++) begin
            r = int'($urandom_range(6656, 0)) - 3328;
            cv[i] = r[15:0];
        end
    endtask

    // Bit-serial reference packing: coefficient i, bit b lands at stream bit i*d+b.
    task automatic build_exp(input int d);
        int v;
        int p;
        for (int i = 0; i < 384; i++) expb[i] = 8'd0;
        for (int i = 0; i < 256; i++) begin
            if (d == 12) begin
                v = int'($signed(cv[i]));
                if (v < 0) v = v + 3329;
            end else begin
                v = int'(cv[i]);
            end
            for (int b = 0; b < d; b++) begin
                p = i * d + b;
                expb[p / 8][p % 8] = v[b];
            end
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, {31'd0, m_busy}, 32'd1);
    endtask

    task automatic run_poly(input string tag, input int abort_at, input int stall_at,
                            input int stall_len, input int restart_at, output int n_done);
        int ci;
        int cyc;
        int stall_rem;
        int last_cyc;
        int done_cyc;
        bit held_ok;
        logic [7:0] held;
        ci = 0;
        cyc = 0;
        stall_rem = stall_len;
        last_cyc = -1;
        done_cyc = -1;
        held_ok = 1'b0;
        held = 8'd0;
        n_done = 0;
        got.delete();
        lastf.delete();
        while (cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (m_done) begin
                n_done++;
                done_cyc = cyc;
                break;
            end
            if (abort_at > 0 && ci >= abort_at) break;
            start = (cyc == restart_at);
            coef_valid = (ci < 256);
            coef_data = cv[(ci < 256) ? ci : 255];
            if (got.size() == stall_at && stall_rem > 0) begin
                byte_ready = 1'b0;
                stall_rem--;
                if (m_bvalid) begin
                    if (!held_ok) begin
                        held = m_data;
                        held_ok = 1'b1;
                    end else begin
                        check({tag, "_stall_hold"}, {24'd0, m_data}, {24'd0, held});
                    end
                    check({tag, "_stall_cready"}, {31'd0, m_cready}, 32'd0);
                end
            end else begin
                byte_ready = 1'b1;
            end
            if (coef_valid && m_cready) ci++;
            if (m_bvalid && byte_ready) begin
                got.push_back(m_data);
                lastf.push_back(m_last);
                if (m_last) last_cyc = cyc;
            end
        end
        coef_valid = 1'b0;
        byte_ready = 1'b1;
        start = 1'b0;
        if (abort_at == 0) begin
            check({tag, "_done_seen"}, n_done, 1);
            check({tag, "_done_lat"}, done_cyc, last_cyc + 1);
            check({tag, "_busy_after"}, {31'd0, m_busy}, 32'd0);
        end
    endtask

    task automatic compare_bytes(input string tag, input int d);
        int nb;
        int nlast;
        int lastidx;
        nb = 32 * d;
        nlast = 0;
        lastidx = -1;
        check({tag, "_count"}, got.size(), nb);
        for (int i = 0; i < got.size(); i++) begin
            if (i < nb) check($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, expb[i]});
            if (lastf[i]) begin
                nlast++;
                lastidx = i;
            end
        end
        check({tag, "_nlast"}, nlast, 1);
        check({tag, "_lastidx"}, lastidx, nb - 1);
    endtask

    initial begin
        int nd;
        int extra;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // D=12: 106, 1613 lead -> 6A D0 64
        fill_rand(106, 1613);
        build_exp(12);
        pulse_start("a");
        run_poly("a", 0, -1, 0, 0, nd);
        check("a_b0", {24'd0, got[0]}, 32'h6a);
        check("a_b1", {24'd0, got[1]}, 32'hd0);
        check("a_b2", {24'd0, got[2]}, 32'h64);
        compare_bytes("a", 12);

        // D=12: -1, 0 lead -> 00 0D 00, with a 5-cycle output stall mid-stream
        fill_rand(-1, 0);
        build_exp(12);
        pulse_start("b");
        run_poly("b", 0, 40, 5, 0, nd);
        check("b_b0", {24'd0, got[0]}, 32'h00);
        check("b_b1", {24'd0, got[1]}, 32'h0d);
        check("b_b2", {24'd0, got[2]}, 32'h00);
        compare_bytes("b", 12);

        // start pulsed while busy is ignored: one done, then stay idle
        fill_rand(3328, -3328);
        build_exp(12);
        pulse_start("c");
        run_poly("c", 0, -1, 0, 60, nd);
        compare_bytes("c", 12);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_done || m_busy) extra++;
        end
        check("c_no_rerun", extra, 0);

        // Reset after 100 coefficients aborts; a fresh polynomial follows
        fill_rand(1234, -5);
        pulse_start("d");
        run_poly("d", 100, -1, 0, 0, nd);
        rst = 1'b1;
        #1;
        check_zero("d_rst_async");
        @(negedge clk);
        check_zero("d_rst_hold");
        rst = 1'b0;
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_bvalid || m_busy || m_done) extra++;
        end
        check("d_quiet", extra, 0);
        fill_rand(-2000, 777);
        build_exp(12);
        pulse_start("e");
        run_poly("e", 0, -1, 0, 0, nd);
        compare_bytes("e", 12);

        // D=1: alternating 1,0 -> 32 bytes of 0x55
        sel = 1'b1;
        for (int i = 0; i < 256; i++) cv[i] = (i % 2 == 0) ? 16'd1 : 16'd0;
        build_exp(1);
        pulse_start("f");
        run_poly("f", 0, -1, 0, 0, nd);
        check("f_b0", {24'd0, got[0]}, 32'h55);
        check("f_b31", {24'd0, got[31]}, 32'h55);
        compare_bytes("f", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
